fifo_bank_status: RTL and testbench

- Five-lane FIFO bank that sits at the other end of the control state machine's status interface.
- Produces the per-lane Fifo_empties and Fifo_errors vectors that the state machine consumes.
- Takes the state machine's programmable thresholds and turns them into per-lane almost-full and almost-empty flags.
- Provides the data path (write lane select, read lane select) that the thresholds and status flags describe.

---
 rtl/fifo_bank_status.sv | 156 +++++++++++++++
 tb/tb_fifo_bank_status.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bank_status.sv
// Five-lane FIFO bank that feeds per-lane empty/full/threshold/error status
// back to the control state machine; pops return registered data one cycle later.
module fifo_bank_status #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BITBUS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_in,
  input  logic [BITBUS-1:0] umbral_af,
  input  logic [BITBUS-1:0] umbral_ae,
  input  logic              wr_en,
  input  logic [2:0]        wr_sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic [2:0]        rd_sel,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [4:0]        Fifo_empties,
  output logic [4:0]        Fifo_full,
  output logic [4:0]        Fifo_almost_full,
  output logic [4:0]        Fifo_almost_empty,
  output logic [4:0]        Fifo_errors
);

  localparam int unsigned LANES = 5;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [LANES][DEPTH];

  logic [BITBUS-1:0] cnt_q  [LANES];
  logic [BITBUS-1:0] cnt_d  [LANES];
  logic [PTR_W-1:0]  wptr_q [LANES];
  logic [PTR_W-1:0]  wptr_d [LANES];
  logic [PTR_W-1:0]  rptr_q [LANES];
  logic [PTR_W-1:0]  rptr_d [LANES];

  logic [BITBUS-1:0] af_q, af_d;
  logic [BITBUS-1:0] ae_q, ae_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic [LANES-1:0]  err_q, err_d;

  logic [LANES-1:0]  push_ok;
  logic [LANES-1:0]  pop_ok;
  logic [LANES-1:0]  new_err;

  // Per-lane push/pop arbitration and next-state computation
  always_comb begin
    af_d       = af_q;
    ae_d       = ae_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    push_ok    = '0;
    pop_ok     = '0;
    new_err    = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt_d[i]  = cnt_q[i];
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
    end

    if (init_in) begin
      af_d = umbral_af;
      ae_d = umbral_ae;
    end

    for (int i = 0; i < LANES; i++) begin
      logic wr_hit;
      logic rd_hit;
      logic is_empty;
      logic is_full;
      wr_hit   = wr_en && (wr_sel == 3'(i));
      rd_hit   = rd_en && (rd_sel == 3'(i));
      is_empty = (cnt_q[i] == '0);
      is_full  = (cnt_q[i] == BITBUS'(DEPTH));

      // A pop on a full lane frees the slot the same-cycle push lands in
      pop_ok[i]  = rd_hit && !is_empty;
      push_ok[i] = wr_hit && (!is_full || pop_ok[i]);
      new_err[i] = (rd_hit && is_empty) || (wr_hit && is_full && !pop_ok[i]);

      if (pop_ok[i]) begin
        data_out_d = mem_q[i][rptr_q[i]];
        valid_d    = 1'b1;
        rptr_d[i]  = rptr_q[i] + PTR_W'(1);
      end
      if (push_ok[i]) begin
        wptr_d[i] = wptr_q[i] + PTR_W'(1);
      end
      if (push_ok[i] && !pop_ok[i]) begin
        cnt_d[i] = cnt_q[i] + BITBUS'(1);
      end else if (pop_ok[i] && !push_ok[i]) begin
        cnt_d[i] = cnt_q[i] - BITBUS'(1);
      end
    end

    // A fresh error outranks a simultaneous clear
    err_d = (err_q & ~{LANES{err_clr}}) | new_err;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      af_q       <= BITBUS'(DEPTH - 1);
      ae_q       <= BITBUS'(1);
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= '0;
      for (int i = 0; i < LANES; i++) begin
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      af_q       <= af_d;
      ae_q       <= ae_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      for (int i = 0; i < LANES; i++) begin
        cnt_q[i]  <= cnt_d[i];
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
      end
    end
  end

  // Storage is never cleared; reset only suppresses the write
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (reset && push_ok[i]) begin
        mem_q[i][wptr_q[i]] <= data_in;
      end
    end
  end

  always_comb begin
    Fifo_empties      = '0;
    Fifo_full         = '0;
    Fifo_almost_full  = '0;
    Fifo_almost_empty = '0;
    for (int i = 0; i < LANES; i++) begin
      Fifo_empties[i]      = (cnt_q[i] == '0);
      Fifo_full[i]         = (cnt_q[i] == BITBUS'(DEPTH));
      Fifo_almost_full[i]  = (cnt_q[i] >= af_q);
      Fifo_almost_empty[i] = (cnt_q[i] <= ae_q);
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_q;
  assign Fifo_errors = err_q;

endmodule

// File: tb/tb_fifo_bank_status.sv
// Directed bench for fifo_bank_status: hand-computed expectations checked with
// immediate assertions on the falling edge after each rising edge.
module tb_fifo_bank_status;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned BITBUS = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              init_in;
  logic [BITBUS-1:0] umbral_af;
  logic [BITBUS-1:0] umbral_ae;
  logic              wr_en;
  logic [2:0]        wr_sel;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [2:0]        rd_sel;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [4:0]        Fifo_empties;
  logic [4:0]        Fifo_full;
  logic [4:0]        Fifo_almost_full;
  logic [4:0]        Fifo_almost_empty;
  logic [4:0]        Fifo_errors;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_bank_status #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BITBUS(BITBUS)) dut (
    .clk               (clk),
    .reset             (reset),
    .init_in           (init_in),
    .umbral_af         (umbral_af),
    .umbral_ae         (umbral_ae),
    .wr_en             (wr_en),
    .wr_sel            (wr_sel),
    .data_in           (data_in),
    .rd_en             (rd_en),
    .rd_sel            (rd_sel),
    .err_clr           (err_clr),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .Fifo_empties      (Fifo_empties),
    .Fifo_full         (Fifo_full),
    .Fifo_almost_full  (Fifo_almost_full),
    .Fifo_almost_empty (Fifo_almost_empty),
    .Fifo_errors       (Fifo_errors)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    init_in = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic push(input logic [2:0] sel, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_sel = sel; data_in = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pop(input logic [2:0] sel);
    rd_en = 1'b1; rd_sel = sel;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; idle();
    umbral_af = '0; umbral_ae = '0; wr_sel = '0; rd_sel = '0; data_in = '0;
    @(negedge clk);

    // Reset
    step(); step();
    chk("rst_empties", 32'(Fifo_empties), 32'h1F);
    chk("rst_errors", 32'(Fifo_errors), 32'h00);
    chk("rst_ae", 32'(Fifo_almost_empty), 32'h1F);
    chk("rst_af", 32'(Fifo_almost_full), 32'h00);
    chk("rst_full", 32'(Fifo_full), 32'h00);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_dout", 32'(data_out), 32'h00);
    reset = 1'b1;
    step();
    chk("post_rst_empties", 32'(Fifo_empties), 32'h1F);

    // Threshold load and fill of lane 1
    init_in = 1'b1; umbral_af = 3'd1; umbral_ae = 3'd1;
    step();
    init_in = 1'b0; umbral_af = 3'd7; umbral_ae = 3'd7;
    chk("thr_af_empty", 32'(Fifo_almost_full), 32'h00);
    push(3'd1, 6'h15);
    chk("l1_empties", 32'(Fifo_empties), 32'h1D);
    chk("l1_af", 32'(Fifo_almost_full), 32'h02);
    chk("l1_ae_cnt1", 32'(Fifo_almost_empty), 32'h1F);
    push(3'd1, 6'h2A);
    chk("l1_ae_cnt2", 32'(Fifo_almost_empty), 32'h1D);

    // Order and wrap on lane 3
    push(3'd3, 6'h01); push(3'd3, 6'h02); push(3'd3, 6'h03); push(3'd3, 6'h04);
    chk("l3_full", 32'(Fifo_full), 32'h08);
    pop(3'd3);
    chk("l3_v1", 32'(valid_out), 32'h1);
    chk("l3_d1", 32'(data_out), 32'h01);
    pop(3'd3);
    chk("l3_d2", 32'(data_out), 32'h02);
    push(3'd3, 6'h05);
    chk("l3_v_nopop", 32'(valid_out), 32'h0);
    chk("l3_d_hold", 32'(data_out), 32'h02);
    push(3'd3, 6'h06);
    chk("l3_full_wrap", 32'(Fifo_full), 32'h08);
    pop(3'd3); chk("l3_d3", 32'(data_out), 32'h03);
    pop(3'd3); chk("l3_d4", 32'(data_out), 32'h04);
    pop(3'd3); chk("l3_d5", 32'(data_out), 32'h05);
    pop(3'd3);
    chk("l3_d6", 32'(data_out), 32'h06);
    chk("l3_v6", 32'(valid_out), 32'h1);
    chk("l3_empty", 32'(Fifo_empties), 32'h1D);
    step();
    chk("l3_v_idle", 32'(valid_out), 32'h0);
    chk("l3_d_idle", 32'(data_out), 32'h06);

    // Overflow on lane 0, then clear
    push(3'd0, 6'h11); push(3'd0, 6'h12); push(3'd0, 6'h13); push(3'd0, 6'h14);
    chk("l0_no_err", 32'(Fifo_errors), 32'h00);
    push(3'd0, 6'h3F);
    chk("ovf_err", 32'(Fifo_errors), 32'h01);
    chk("ovf_full", 32'(Fifo_full), 32'h01);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_clr", 32'(Fifo_errors), 32'h00);
    pop(3'd0); chk("l0_d1", 32'(data_out), 32'h11);
    pop(3'd0); chk("l0_d2", 32'(data_out), 32'h12);
    pop(3'd0); chk("l0_d3", 32'(data_out), 32'h13);
    pop(3'd0); chk("l0_d4", 32'(data_out), 32'h14);
    chk("l0_empty", 32'(Fifo_empties), 32'h1F & ~32'h02);

    // Underflow with simultaneous push on empty lane 4
    wr_en = 1'b1; wr_sel = 3'd4; data_in = 6'h0A;
    rd_en = 1'b1; rd_sel = 3'd4;
    step();
    idle();
    chk("unf_err", 32'(Fifo_errors), 32'h10);
    chk("unf_valid", 32'(valid_out), 32'h0);
    chk("unf_empties", 32'(Fifo_empties), 32'h0D);
    chk("unf_dout_hold", 32'(data_out), 32'h14);

    // New error wins over a same-cycle clear
    err_clr = 1'b1;
    pop(3'd0);
    err_clr = 1'b0;
    chk("clr_vs_new", 32'(Fifo_errors), 32'h01);

    // Out-of-range selects are ignored
    wr_en = 1'b1; wr_sel = 3'd5; data_in = 6'h33;
    rd_en = 1'b1; rd_sel = 3'd7;
    step();
    idle();
    chk("oor_errors", 32'(Fifo_errors), 32'h01);
    chk("oor_empties", 32'(Fifo_empties), 32'h0D);
    chk("oor_valid", 32'(valid_out), 32'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr2", 32'(Fifo_errors), 32'h00);

    // Full lane 2 simultaneous push/pop, then reset mid-burst
    push(3'd2, 6'h21); push(3'd2, 6'h22); push(3'd2, 6'h23); push(3'd2, 6'h24);
    chk("l2_full", 32'(Fifo_full), 32'h04);
    wr_en = 1'b1; wr_sel = 3'd2; data_in = 6'h25;
    rd_en = 1'b1; rd_sel = 3'd2;
    step();
    chk("l2_sim_err", 32'(Fifo_errors), 32'h00);
    chk("l2_sim_full", 32'(Fifo_full), 32'h04);
    chk("l2_sim_d", 32'(data_out), 32'h21);
    chk("l2_sim_v", 32'(valid_out), 32'h1);
    data_in = 6'h26;
    reset = 1'b0;
    step();
    chk("mrst_empties", 32'(Fifo_empties), 32'h1F);
    chk("mrst_full", 32'(Fifo_full), 32'h00);
    chk("mrst_valid", 32'(valid_out), 32'h0);
    chk("mrst_dout", 32'(data_out), 32'h00);
    chk("mrst_errors", 32'(Fifo_errors), 32'h00);
    idle();
    reset = 1'b1;
    step();

    // Thresholds back to DEPTH-1 / 1 and pointers restart at 0
    push(3'd2, 6'h30);
    chk("rst_thr_af1", 32'(Fifo_almost_full), 32'h00);
    push(3'd2, 6'h31);
    chk("rst_thr_ae2", 32'(Fifo_almost_empty), 32'h1B);
    push(3'd2, 6'h32);
    chk("rst_thr_af3", 32'(Fifo_almost_full), 32'h04);
    pop(3'd2);
    chk("rst_ptr_d", 32'(data_out), 32'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
